serial_csel_subtractor: RTL and testbench

//   Multi-cycle unsigned/two's-complement subtractor: DIFF = A - B, computed one

---
 rtl/serial_csel_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_csel_subtractor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_csel_subtractor.sv
// Multi-cycle subtractor: DIFF = A - B, one SLICE-bit carry-select slice per clock,
// LSB slice first, with single-entry valid/ready buffering on input and output.
module serial_csel_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSL  = WIDTH / SLICE;
  localparam int unsigned IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int unsigned SW   = SLICE + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, out_valid_q, busy_q;

  logic [SLICE-1:0]  a_sl, nb_sl;
  logic [SW-1:0]     s0, s1, sel;

  // Slice datapath: both carry-in candidates, registered carry picks one
  always_comb begin
    a_sl  = a_q[idx_q*SLICE +: SLICE];
    nb_sl = ~b_q[idx_q*SLICE +: SLICE];
    s0    = SW'(a_sl) + SW'(nb_sl);
    s1    = s0 + SW'(1);
    sel   = carry_q ? s1 : s0;
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[idx_q*SLICE +: SLICE] = sel[SLICE-1:0];
        carry_d = sel[SLICE];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NSL - 1)) begin
          state_d  = DONE;
          borrow_d = ~sel[SLICE];
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; handshake flags follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == RUN);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_csel_subtractor.sv
// Directed bench for serial_csel_subtractor: latency, borrow ripple, overflow,
// output back-pressure, mid-operation reset and a short pseudo-random sweep.
module tb_serial_csel_subtractor;

  localparam int unsigned W = 16;

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         out_valid, out_ready;
  logic [W-1:0] diff;
  logic         borrow_out, ovf, busy;

  int n_vec = 0;
  int n_err = 0;

  serial_csel_subtractor #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, check latency and result, stall `stall` cycles, then drain
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input int stall);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("diff", 32'(diff), 32'(ed));
    chk("borrow", 32'(borrow_out), 32'(eb));
    chk("ovf", 32'(ovf), 32'(eo));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_diff", 32'(diff), 32'(ed));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rd;
    logic         rbo, rov;
    int           guard;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    do_op(16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 0);
    do_op(16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 0);
    do_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 0);
    do_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1);
    do_op(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);
    do_op(16'h0005, 16'h8000, 16'h8005, 1'b1, 1'b1, 2);

    // Back-pressure: held result, ignored in_valid, no accept in the drain cycle
    a = 16'h0050; b = 16'h0051; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    a = 16'hAAAA; b = 16'h1111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_diff", 32'(diff), 32'hFFFF);
      chk("bp_hold_borrow", 32'(borrow_out), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    tick();

    // Reset during RUN cycle 2
    a = 16'h4321; b = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op(16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b0, 0);

    // Pseudo-random operands against an arithmetic reference
    for (int n = 0; n < 40; n++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rd  = ra - rb;
      rbo = (ra < rb);
      rov = (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]);
      do_op(ra, rb, rd, rbo, rov, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
